spi_av_reader: RTL and testbench

Avalon-MM read-side register block for the SpeedSPI controller, the read counterpart of the command/init/open/speed write decoder. It captures completion events and responses from the SPI engine into sticky status bits and a small receive FIFO, and returns them to the host over a fixed-latency Avalon read port. It sits between the SPI engine and the `s0` slave alongside the write decoder, sharing clock, reset and address space.

---
 rtl/spi_av_reader.sv | 134 +++++++++++++
 tb/tb_spi_av_reader.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/spi_av_reader.sv
// Avalon-MM read-side register block for the SpeedSPI controller: sticky event flags, last command
// response and a receive-byte FIFO, returned with fixed 1-cycle latency and no waitrequest.
module spi_av_reader #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        avs_s0_read,
    input  logic [15:0] avs_s0_address,
    output logic [31:0] avs_s0_readdata,
    output logic        avs_s0_readdatavalid,
    input  logic        com_done,
    input  logic [31:0] com_resp,
    input  logic        init_done,
    input  logic        init_err,
    input  logic        busy,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    input  logic [1:0]  speed
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    localparam logic [2:0] IDX_STATUS  = 3'd0;
    localparam logic [2:0] IDX_RESP    = 3'd1;
    localparam logic [2:0] IDX_RXDATA  = 3'd2;
    localparam logic [2:0] IDX_RXLEVEL = 3'd3;
    localparam logic [2:0] IDX_SPEED   = 3'd6;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;

    logic          com_done_flag;
    logic          init_done_flag;
    logic          init_err_flag;
    logic          rx_overflow_flag;
    logic [31:0]   resp;

    logic          rd_acc;
    logic          hit;
    logic [2:0]    idx;
    logic          fifo_empty;
    logic          fifo_full;
    logic          pop;
    logic          push;
    logic          ovf_set;
    logic          status_clr;
    logic [31:0]   rdata;

    // A read overlapping reset is dropped entirely, so it never pops or clears.
    assign rd_acc     = avs_s0_read & ~rst;
    assign hit        = (avs_s0_address[15:3] == 13'd0);
    assign idx        = avs_s0_address[2:0];
    assign fifo_empty = (count == '0);
    assign fifo_full  = (count == CW'(FIFO_DEPTH));
    assign pop        = rd_acc & hit & (idx == IDX_RXDATA) & ~fifo_empty;
    assign push       = rx_valid & (~fifo_full | pop);
    assign ovf_set    = rx_valid & fifo_full & ~pop;
    assign status_clr = rd_acc & hit & (idx == IDX_STATUS);

    always_comb begin
        rdata = 32'h0;
        if (hit) begin
            case (idx)
                IDX_STATUS:  rdata = {25'h0, fifo_full, fifo_empty, rx_overflow_flag,
                                      init_err_flag, init_done_flag, com_done_flag, busy};
                IDX_RESP:    rdata = resp;
                IDX_RXDATA:  rdata = fifo_empty ? 32'h8000_0000 : {24'h0, mem[rd_ptr]};
                IDX_RXLEVEL: rdata = {{(32-CW){1'b0}}, count};
                IDX_SPEED:   rdata = {30'h0, speed};
                default:     rdata = 32'h0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            avs_s0_readdata      <= 32'h0;
            avs_s0_readdatavalid <= 1'b0;
        end else begin
            avs_s0_readdatavalid <= rd_acc;
            avs_s0_readdata      <= rd_acc ? rdata : 32'h0;
        end
    end

    // Set wins over a coincident clearing STATUS read.
    always_ff @(posedge clk) begin
        if (rst) begin
            com_done_flag    <= 1'b0;
            init_done_flag   <= 1'b0;
            init_err_flag    <= 1'b0;
            rx_overflow_flag <= 1'b0;
            resp             <= 32'h0;
        end else begin
            com_done_flag    <= com_done  | (com_done_flag    & ~status_clr);
            init_done_flag   <= init_done | (init_done_flag   & ~status_clr);
            init_err_flag    <= init_err  | (init_err_flag    & ~status_clr);
            rx_overflow_flag <= ovf_set   | (rx_overflow_flag & ~status_clr);
            if (com_done) begin
                resp <= com_resp;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= rx_data;
        end
    end

endmodule

// File: tb/tb_spi_av_reader.sv
// Randomised and directed bench for spi_av_reader with a queue-based reference model and scoreboard.
module tb_spi_av_reader;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        avs_s0_read;
    logic [15:0] avs_s0_address;
    logic [31:0] avs_s0_readdata;
    logic        avs_s0_readdatavalid;
    logic        com_done;
    logic [31:0] com_resp;
    logic        init_done;
    logic        init_err;
    logic        busy;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic [1:0]  speed;

    spi_av_reader #(.FIFO_DEPTH(DEPTH)) dut (
        .clk                  (clk),
        .rst                  (rst),
        .avs_s0_read          (avs_s0_read),
        .avs_s0_address       (avs_s0_address),
        .avs_s0_readdata      (avs_s0_readdata),
        .avs_s0_readdatavalid (avs_s0_readdatavalid),
        .com_done             (com_done),
        .com_resp             (com_resp),
        .init_done            (init_done),
        .init_err             (init_err),
        .busy                 (busy),
        .rx_valid             (rx_valid),
        .rx_data              (rx_data),
        .speed                (speed)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit mon_en = 1'b0;

    // Reference model state
    logic [7:0]  m_fifo[$];
    logic [31:0] m_resp;
    bit          m_cd, m_id, m_ie, m_ovf;

    logic [31:0] exp_q[$];
    string       name_q[$];

    task automatic model_reset();
        m_fifo.delete();
        m_resp = 32'h0;
        m_cd = 0; m_id = 0; m_ie = 0; m_ovf = 0;
    endtask

    // One bus cycle: drive inputs, predict, update the model, then advance.
    task automatic step(input bit rd, input logic [15:0] a, input bit cd, input logic [31:0] cr,
                        input bit idn, input bit ie, input bit rv, input logic [7:0] rxd,
                        input bit r);
        logic [31:0] exp;
        bit          hit, do_pop, clr, full;
        avs_s0_read    = rd;
        avs_s0_address = a;
        com_done       = cd;
        com_resp       = cr;
        init_done      = idn;
        init_err       = ie;
        rx_valid       = rv;
        rx_data        = rxd;
        rst            = r;
        if (r) begin
            model_reset();
        end else begin
            hit    = (a >> 3) == 0;
            exp    = 32'h0;
            do_pop = 0;
            clr    = 0;
            if (rd && hit) begin
                case (a[2:0])
                    3'd0: begin
                        exp = {25'h0, m_fifo.size() == DEPTH, m_fifo.size() == 0, m_ovf,
                               m_ie, m_id, m_cd, busy};
                        clr = 1;
                    end
                    3'd1: exp = m_resp;
                    3'd2: begin
                        if (m_fifo.size() == 0) exp = 32'h8000_0000;
                        else begin
                            exp = {24'h0, m_fifo[0]};
                            do_pop = 1;
                        end
                    end
                    3'd3: exp = m_fifo.size();
                    3'd6: exp = {30'h0, speed};
                    default: exp = 32'h0;
                endcase
            end
            if (rd) begin
                exp_q.push_back(exp);
                name_q.push_back($sformatf("read@%04h", a));
            end
            if (clr) begin
                m_cd = 0; m_id = 0; m_ie = 0; m_ovf = 0;
            end
            if (do_pop) void'(m_fifo.pop_front());
            full = m_fifo.size() == DEPTH;
            if (rv) begin
                if (full) m_ovf = 1;
                else m_fifo.push_back(rxd);
            end
            if (cd) begin
                m_cd = 1;
                m_resp = cr;
            end
            if (idn) m_id = 1;
            if (ie) m_ie = 1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 16'h0, 0, 32'h0, 0, 0, 0, 8'h0, 0);
    endtask

    task automatic rd(input logic [15:0] a);
        step(1, a, 0, 32'h0, 0, 0, 0, 8'h0, 0);
    endtask

    task automatic push(input logic [7:0] d);
        step(0, 16'h0, 0, 32'h0, 0, 0, 1, d, 0);
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        if (mon_en) begin
            if (avs_s0_readdatavalid) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_valid: readdatavalid=1 data=%08h, required no response",
                             avs_s0_readdata);
                end else begin
                    automatic logic [31:0] e = exp_q.pop_front();
                    automatic string nm = name_q.pop_front();
                    if (avs_s0_readdata !== e) begin
                        errors++;
                        $display("FAIL %s: got %08h, required %08h", nm, avs_s0_readdata, e);
                    end
                end
            end else begin
                checks++;
                if (avs_s0_readdatavalid !== 1'b0 || avs_s0_readdata !== 32'h0) begin
                    errors++;
                    $display("FAIL idle_bus: valid=%b data=%08h, required valid=0 data=0",
                             avs_s0_readdatavalid, avs_s0_readdata);
                end
            end
        end
    end

    initial begin
        busy  = 0;
        speed = 2'b10;
        model_reset();
        step(0, 16'h0, 0, 32'h0, 0, 0, 0, 8'h0, 1);
        step(0, 16'h0, 0, 32'h0, 0, 0, 0, 8'h0, 1);
        mon_en = 1'b1;
        idle(2);

        // Reset state over the whole map plus one out-of-range address
        for (int i = 0; i < 8; i++) rd(16'(i));
        rd(16'h0008);
        idle(2);

        // Command response and sticky flag
        step(0, 16'h0, 1, 32'hDEAD_BEEF, 0, 0, 0, 8'h0, 0);
        rd(16'd1);
        rd(16'd0);
        rd(16'd0);

        // Fill, overflow, drain, empty
        push(8'h11); push(8'h22); push(8'h33); push(8'h44);
        rd(16'd0); rd(16'd3);
        push(8'h55);
        rd(16'd0);
        for (int i = 0; i < 5; i++) rd(16'd2);

        // Full FIFO with simultaneous pop and push
        push(8'hA1); push(8'hA2); push(8'hA3); push(8'hA4);
        step(1, 16'd2, 0, 32'h0, 0, 0, 1, 8'h99, 0);
        rd(16'd3); rd(16'd0);
        for (int i = 0; i < 5; i++) rd(16'd2);

        // Empty FIFO with simultaneous pop and push
        step(1, 16'd2, 0, 32'h0, 0, 0, 1, 8'h77, 0);
        rd(16'd3); rd(16'd2);

        // STATUS read coincident with init_err: set wins
        step(1, 16'd0, 0, 32'h0, 0, 1, 0, 8'h0, 0);
        rd(16'd0);

        // Reset mid-transaction
        busy = 1;
        step(0, 16'h0, 1, 32'h1234_5678, 1, 0, 1, 8'h01, 0);
        push(8'h02); push(8'h03);
        step(1, 16'd0, 0, 32'h0, 0, 0, 0, 8'h0, 1);
        busy = 0;
        rd(16'd3); rd(16'd0); rd(16'd1);
        idle(2);

        // Randomised traffic
        for (int i = 0; i < 3000; i++) begin
            automatic logic [15:0] a;
            busy = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 99) == 0) speed = 2'($urandom);
            a = ($urandom_range(0, 9) == 0) ? 16'($urandom) : 16'($urandom_range(0, 7));
            step($urandom_range(0, 2) != 0, a,
                 $urandom_range(0, 9) == 0, $urandom,
                 $urandom_range(0, 14) == 0, $urandom_range(0, 14) == 0,
                 $urandom_range(0, 2) == 0, 8'($urandom),
                 $urandom_range(0, 299) == 0);
        end
        idle(3);

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL missing_responses: %0d outstanding, required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
